relu_maxpool: RTL and testbench
===============================

RELU_MAXPOOL -- requirements
Module: relu_maxpool

Interface
REQ-001 Parameter dw, default 20: width of the convolution result and pooled output words.
REQ-002 Parameter os, default 4: edge length of the square convolution output map; even, >=2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 clr  input  1  synchronous frame abort.
REQ-006 din  input  dw  convolution result, signed two's complement, raster order (row-major).
REQ-007 din_v  input  1  din valid.
REQ-008 din_rdy  output  1  block accepts din this cycle.
REQ-009 dout  output  dw  pooled result, non-negative.
REQ-010 dout_v  output  1  dout valid.
REQ-011 dout_rdy  input  1  downstream accepts dout this cycle.
REQ-012 frame_done  output  1  one-cycle pulse after the last sample of a frame is accepted.
REQ-013 busy  output  1  high while a frame is partially received.

Function
REQ-014 Accept: a sample is accepted when din_v=1 and din_rdy=1 in the same cycle.
REQ-015 din_rdy = (dout_v=0) or (dout_rdy=1), combinational; it does not depend on din_v.
REQ-016 ReLU: the block substitutes 0 for each accepted sample with MSB=1 before pooling.
REQ-017 Position counters: row r and column c, each 0..os-1; on accept, c increments; at c=os-1, c wraps to 0 and r increments; at r=os-1,c=os-1, both wrap to 0.
REQ-018 Partial buffer: pbuf holds os/2 entries of dw bits, indexed by c/2.
REQ-019 Even r, even c: pbuf[c/2] <= x. Even r, odd c: pbuf[c/2] <= max(pbuf[c/2], x).
REQ-020 Odd r, even c: pbuf[c/2] <= max(pbuf[c/2], x). Odd r, odd c: dout <= max(pbuf[c/2], x) and dout_v <= 1.
REQ-021 Max comparison: unsigned, after ReLU; on a tie, either operand gives the result.
REQ-022 Latency: dout_v rises on the cycle after the accept at odd r, odd c; each frame produces (os/2)^2 outputs, in pooled raster order.
REQ-023 dout_v clears on the cycle after dout_v=1 and dout_rdy=1, unless a new result loads in that same cycle, in which case dout_v stays 1 with the new value.
REQ-024 dout holds stable while dout_v=1 and dout_rdy=0.
REQ-025 frame_done: pulses 1 on the cycle after the accept at r=os-1,c=os-1, and is 0 otherwise.
REQ-026 busy: 1 when (r,c) is not equal to (0,0).
REQ-027 clr: sets r, c, pbuf, dout_v and frame_done to 0 on the next edge; a sample presented in the same cycle is discarded; dout is don't-care after clr.
REQ-028 Back-to-back frames: a new frame may start on the cycle after the final accept, with no idle cycle required.

Reset
REQ-029 rst has priority over clr; on the next edge it sets r=0, c=0, all pbuf entries=0, dout=0, dout_v=0 and frame_done=0.
REQ-030 After reset, din_rdy=1, and busy=0.
REQ-031 Reset mid-frame discards the partial frame and any pending output.

Structure
REQ-032 Shared package: the pooling window constant (2) and the helper function for dw-bit unsigned max; dw and os remain module parameters.
REQ-033 One sub-module, relu_max2: a combinational ReLU of the new sample plus max against a dw-bit operand; all counters and buffers stay in relu_maxpool.

Verification (os=4, dw=20)
REQ-034 Ramp: frame 1..16 with dout_rdy held at 1 -> dout sequence 6, 8, 14, 16; frame_done pulses once, one cycle after the 16th accept.
REQ-035 ReLU: a frame of all -5 (20'hFFFFB) -> four outputs of 0; a frame with only sample 11 = -1 and others 0, except sample 0 = 3 -> outputs 3, 0, 0, 0.
REQ-036 Backpressure: ramp frame with dout_rdy=0 from the first output -> dout=6 held, din_rdy=0, no further accepts until dout_rdy=1; all four outputs then arrive unchanged.
REQ-037 Abort: clr after 7 accepts, then a full ramp frame -> exactly four outputs 6, 8, 14, 16; busy=0 on the cycle after clr.
REQ-038 Reset mid-frame: rst after 9 accepts -> dout_v=0, busy=0 next cycle; the following frame pools correctly.
REQ-039 Back-to-back: two frames streamed with din_v always high and dout_rdy=1 -> eight outputs, two frame_done pulses 16 cycles apart.

Source files
------------

// File: rtl/relu_maxpool_pkg.sv
// Shared constants and helpers for the ReLU + 2x2 max-pool block.
package relu_maxpool_pkg;

    localparam int POOL   = 2;
    localparam int MAX_DW = 64;

    function automatic logic [MAX_DW-1:0] umax(
        input logic [MAX_DW-1:0] a,
        input logic [MAX_DW-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/relu_max2.sv
// Combinational ReLU of a new sample and unsigned max against an operand.
module relu_max2
    import relu_maxpool_pkg::*;
#(
    parameter int dw = 20
) (
    input  logic [dw-1:0] x_i,
    input  logic [dw-1:0] opnd_i,
    output logic [dw-1:0] relu_o,
    output logic [dw-1:0] max_o
);

    logic [MAX_DW-1:0] wide;
    logic              unused_hi;

    assign relu_o    = x_i[dw-1] ? '0 : x_i;
    assign wide      = umax(MAX_DW'(relu_o), MAX_DW'(opnd_i));
    assign max_o     = wide[dw-1:0];
    assign unused_hi = |wide[MAX_DW-1:dw];

endmodule

// File: rtl/relu_maxpool.sv
// Streaming ReLU followed by 2x2 max pooling over an os x os raster map.
module relu_maxpool
    import relu_maxpool_pkg::*;
#(
    parameter int dw = 20,
    parameter int os = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [dw-1:0] din,
    input  logic          din_v,
    output logic          din_rdy,
    output logic [dw-1:0] dout,
    output logic          dout_v,
    input  logic          dout_rdy,
    output logic          frame_done,
    output logic          busy
);

    localparam int CW = $clog2(os);
    localparam int NB = os / POOL;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic [dw-1:0] pbuf_q [NB];
    logic [dw-1:0] pbuf_d [NB];
    logic [dw-1:0] dout_q, dout_d;
    logic          dout_v_q, dout_v_d;
    logic          fd_q, fd_d;

    logic [IW-1:0] idx;
    logic [dw-1:0] relu_x;
    logic [dw-1:0] max_x;
    logic          accept;
    logic          last_c;
    logic          last_r;

    assign din_rdy    = !dout_v_q || dout_rdy;
    assign dout       = dout_q;
    assign dout_v     = dout_v_q;
    assign frame_done = fd_q;
    assign busy       = (r_q != '0) || (c_q != '0);

    assign idx    = IW'(c_q >> $clog2(POOL));
    assign accept = din_v && din_rdy && !clr;
    assign last_c = (c_q == CW'(os - 1));
    assign last_r = (r_q == CW'(os - 1));

    relu_max2 #(.dw(dw)) u_relu_max2 (
        .x_i    (din),
        .opnd_i (pbuf_q[idx]),
        .relu_o (relu_x),
        .max_o  (max_x)
    );

    always_comb begin
        r_d      = r_q;
        c_d      = c_q;
        pbuf_d   = pbuf_q;
        dout_d   = dout_q;
        dout_v_d = dout_v_q && !dout_rdy;
        fd_d     = 1'b0;
        if (clr) begin
            r_d      = '0;
            c_d      = '0;
            dout_v_d = 1'b0;
            for (int i = 0; i < NB; i++) pbuf_d[i] = '0;
        end else if (accept) begin
            c_d  = last_c ? '0 : c_q + 1'b1;
            fd_d = last_c && last_r;
            if (last_c) r_d = last_r ? '0 : r_q + 1'b1;
            // Row parity selects start/accumulate; odd/odd closes a window.
            unique case ({r_q[0], c_q[0]})
                2'b00:        pbuf_d[idx] = relu_x;
                2'b01, 2'b10: pbuf_d[idx] = max_x;
                2'b11: begin
                    dout_d   = max_x;
                    dout_v_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= '0;
            c_q      <= '0;
            dout_q   <= '0;
            dout_v_q <= 1'b0;
            fd_q     <= 1'b0;
            for (int i = 0; i < NB; i++) pbuf_q[i] <= '0;
        end else begin
            r_q      <= r_d;
            c_q      <= c_d;
            dout_q   <= dout_d;
            dout_v_q <= dout_v_d;
            fd_q     <= fd_d;
            pbuf_q   <= pbuf_d;
        end
    end

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed scoreboard bench for relu_maxpool (os=4, dw=20).
module tb_relu_maxpool;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [19:0] din;
    logic        din_v;
    logic        din_rdy;
    logic [19:0] dout;
    logic        dout_v;
    logic        dout_rdy;
    logic        frame_done;
    logic        busy;

    relu_maxpool #(.dw(20), .os(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .din        (din),
        .din_v      (din_v),
        .din_rdy    (din_rdy),
        .dout       (dout),
        .dout_v     (dout_v),
        .dout_rdy   (dout_rdy),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    logic [19:0] q[$];
    int          fr[16];
    int          pos    = 0;
    bit          fd_exp = 1'b0;
    bit          in_reset;
    int          fd_cnt  = 0;
    int          fd_last = 0;
    int          fd_prev = 0;
    int          pops    = 0;
    int          cyc     = 0;
    bit          a;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int max4(input int w, input int x,
                                input int y, input int z);
        int m;
        m = w;
        if (x > m) m = x;
        if (y > m) m = y;
        if (z > m) m = z;
        return m;
    endfunction

    task automatic tick(output bit acc);
        logic [19:0] e;
        bit          fdn;
        int          r;
        int          c;
        #1;
        if (!in_reset) chk("frame_done", 32'(frame_done), 32'(fd_exp));
        if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_prev = fd_last;
            fd_last = cyc;
        end
        if (dout_v === 1'b1 && dout_rdy) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("dout", 32'(dout), 32'(e));
                pops++;
            end
        end
        acc = din_v && (din_rdy === 1'b1) && !clr && !rst;
        fdn = 1'b0;
        if (rst || clr) begin
            pos = 0;
            q.delete();
        end else if (acc) begin
            fr[pos] = din[19] ? 0 : int'(din);
            r = pos / 4;
            c = pos % 4;
            if ((r % 2 == 1) && (c % 2 == 1))
                q.push_back(20'(max4(fr[pos-5], fr[pos-4],
                                     fr[pos-1], fr[pos])));
            if (pos == 15) fdn = 1'b1;
            pos = (pos + 1) % 16;
        end
        cyc++;
        @(posedge clk);
        fd_exp = fdn;
        @(negedge clk);
    endtask

    task automatic send(input logic [19:0] x);
        bit got;
        got   = 1'b0;
        din   = x;
        din_v = 1'b1;
        for (int n = 0; n < 40 && !got; n++) tick(got);
        if (!got) chk("accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic drain();
        bit g;
        din_v    = 1'b0;
        dout_rdy = 1'b1;
        for (int n = 0; n < 30 && (q.size() != 0 || dout_v === 1'b1); n++)
            tick(g);
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic ramp();
        for (int i = 1; i <= 16; i++) send(20'(i));
    endtask

    initial begin
        rst      = 1'b1;
        clr      = 1'b0;
        din      = '0;
        din_v    = 1'b0;
        dout_rdy = 1'b1;
        in_reset = 1'b1;
        @(negedge clk);
        tick(a);
        tick(a);
        rst      = 1'b0;
        in_reset = 1'b0;
        fd_exp   = 1'b0;
        #1;
        chk("rst_dout_v", 32'(dout_v), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_din_rdy", 32'(din_rdy), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);

        // ramp with open sink
        fd_cnt = 0;
        pops   = 0;
        ramp();
        drain();
        chk("ramp_outputs", 32'(pops), 32'd4);
        chk("ramp_fd_pulses", 32'(fd_cnt), 32'd1);

        // relu frames
        pops = 0;
        for (int i = 0; i < 16; i++) send(20'hFFFFB);
        drain();
        for (int i = 0; i < 16; i++)
            send(i == 0 ? 20'd3 : (i == 11 ? 20'hFFFFF : 20'd0));
        drain();
        chk("relu_outputs", 32'(pops), 32'd8);

        // backpressure
        pops     = 0;
        dout_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) send(20'(i));
        din   = 20'd7;
        din_v = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_din_rdy", 32'(din_rdy), 32'd0);
            chk("bp_dout_hold", 32'(dout), 32'd6);
            chk("bp_dout_v", 32'(dout_v), 32'd1);
            tick(a);
            chk("bp_no_accept", 32'(a), 32'd0);
        end
        dout_rdy = 1'b1;
        for (int i = 7; i <= 16; i++) send(20'(i));
        drain();
        chk("bp_outputs", 32'(pops), 32'd4);

        // abort with clr
        for (int i = 1; i <= 7; i++) send(20'(i));
        chk("abort_busy_pre", 32'(busy), 32'd1);
        clr   = 1'b1;
        din   = 20'd99;
        din_v = 1'b1;
        tick(a);
        clr   = 1'b0;
        din_v = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dout_v", 32'(dout_v), 32'd0);
        pops = 0;
        ramp();
        drain();
        chk("abort_outputs", 32'(pops), 32'd4);

        // reset mid-frame
        for (int i = 1; i <= 9; i++) send(20'(i));
        rst   = 1'b1;
        din_v = 1'b0;
        tick(a);
        rst = 1'b0;
        #1;
        chk("mrst_dout_v", 32'(dout_v), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        pops = 0;
        ramp();
        drain();
        chk("mrst_outputs", 32'(pops), 32'd4);

        // back-to-back frames
        fd_cnt = 0;
        pops   = 0;
        for (int i = 1; i <= 32; i++) send(20'(i));
        drain();
        chk("b2b_outputs", 32'(pops), 32'd8);
        chk("b2b_fd_pulses", 32'(fd_cnt), 32'd2);
        chk("b2b_fd_spacing", 32'(fd_last - fd_prev), 32'd16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
